// File: rtl/ex_pkg.sv
// Shared definitions for the execute stage: bus widths, ALU operation codes,
// result classes, divider state encoding and small arithmetic helpers.
package ex_pkg;

    localparam int RegBus     = 32;
    localparam int RegAddrBus = 5;
    localparam int AluOpBus   = 8;
    localparam int AluSelBus  = 3;

    // ALU operation codes delivered by id_ex
    localparam logic [AluOpBus-1:0] EXE_NOP_OP  = 8'b0000_0000;
    localparam logic [AluOpBus-1:0] EXE_AND_OP  = 8'b0010_0100;
    localparam logic [AluOpBus-1:0] EXE_OR_OP   = 8'b0010_0101;
    localparam logic [AluOpBus-1:0] EXE_XOR_OP  = 8'b0010_0110;
    localparam logic [AluOpBus-1:0] EXE_NOR_OP  = 8'b0010_0111;
    localparam logic [AluOpBus-1:0] EXE_SLL_OP  = 8'b0111_1100;
    localparam logic [AluOpBus-1:0] EXE_SRL_OP  = 8'b0000_0010;
    localparam logic [AluOpBus-1:0] EXE_SRA_OP  = 8'b0000_0011;
    localparam logic [AluOpBus-1:0] EXE_ADDU_OP = 8'b0010_0001;
    localparam logic [AluOpBus-1:0] EXE_SUBU_OP = 8'b0010_0011;
    localparam logic [AluOpBus-1:0] EXE_SLT_OP  = 8'b0010_1010;
    localparam logic [AluOpBus-1:0] EXE_SLTU_OP = 8'b0010_1011;
    localparam logic [AluOpBus-1:0] EXE_DIV_OP  = 8'b0001_1010;
    localparam logic [AluOpBus-1:0] EXE_DIVU_OP = 8'b0001_1011;

    // Result classes selecting which unit drives wdata_o
    localparam logic [AluSelBus-1:0] EXE_RES_NOP   = 3'b000;
    localparam logic [AluSelBus-1:0] EXE_RES_LOGIC = 3'b001;
    localparam logic [AluSelBus-1:0] EXE_RES_SHIFT = 3'b010;
    localparam logic [AluSelBus-1:0] EXE_RES_ARITH = 3'b100;

    // Divider control states
    typedef enum logic [1:0] {
        DivFree   = 2'b00,
        DivByZero = 2'b01,
        DivOn     = 2'b10,
        DivEnd    = 2'b11
    } div_state_e;

    // Two's-complement negation of a 32-bit word
    function automatic logic [31:0] neg32(input logic [31:0] v);
        return (~v) + 32'd1;
    endfunction

    // Magnitude of a signed 32-bit word (0x80000000 maps to itself, read unsigned)
    function automatic logic [31:0] abs32(input logic [31:0] v);
        return v[31] ? neg32(v) : v;
    endfunction

endpackage

// File: rtl/ex_if.sv
// Execute-stage bus: operands and control from id_ex, results towards ex_mem,
// the forwarding path and pipeline control.
interface ex_if;
    import ex_pkg::*;

    logic [AluOpBus-1:0]   aluop_i;
    logic [AluSelBus-1:0]  alusel_i;
    logic [RegBus-1:0]     reg1_i;
    logic [RegBus-1:0]     reg2_i;
    logic [RegAddrBus-1:0] wd_i;
    logic                  wreg_i;

    logic [RegAddrBus-1:0] wd_o;
    logic                  wreg_o;
    logic [RegBus-1:0]     wdata_o;
    logic                  whilo_o;
    logic [RegBus-1:0]     hi_o;
    logic [RegBus-1:0]     lo_o;
    logic                  stallreq_o;

    // Upstream side (id_ex register or a bench driving the stage)
    modport master (
        output aluop_i, alusel_i, reg1_i, reg2_i, wd_i, wreg_i,
        input  wd_o, wreg_o, wdata_o, whilo_o, hi_o, lo_o, stallreq_o
    );

    // Execute stage itself
    modport slave (
        input  aluop_i, alusel_i, reg1_i, reg2_i, wd_i, wreg_i,
        output wd_o, wreg_o, wdata_o, whilo_o, hi_o, lo_o, stallreq_o
    );

endinterface

// File: rtl/ex_div.sv
// Iterative restoring divider: one quotient bit per cycle over 32 cycles,
// with magnitude division and sign fix-up for signed operands.
module ex_div
    import ex_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        signed_div,
    input  logic [31:0] dividend,
    input  logic [31:0] divisor,
    output div_state_e  state,
    output logic        ready,
    output logic [31:0] quot,
    output logic [31:0] rem
);

    div_state_e  state_r;
    div_state_e  next_s;
    logic [5:0]  cnt_r;
    logic [64:0] sr_r;          // {partial remainder (33), quotient (32)}
    logic [31:0] divisor_r;
    logic        neg_quot_r;
    logic        neg_rem_r;
    logic [33:0] trial_s;
    logic [64:0] step_s;

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= DivFree;
        end else begin
            state_r <= next_s;
        end
    end

    // Next-state logic
    always_comb begin
        next_s = state_r;
        case (state_r)
            DivFree: begin
                if (start) begin
                    if (divisor == 32'd0) begin
                        next_s = DivByZero;
                    end else begin
                        next_s = DivOn;
                    end
                end else begin
                    next_s = DivFree;
                end
            end
            DivByZero: next_s = DivEnd;
            DivOn: begin
                if (cnt_r == 6'd31) begin
                    next_s = DivEnd;
                end else begin
                    next_s = DivOn;
                end
            end
            DivEnd:  next_s = DivFree;
            default: next_s = DivFree;
        endcase
    end

    // One restoring step: shift left, trial-subtract the divisor, keep if non-negative
    always_comb begin
        trial_s = sr_r[64:31] - {2'b00, divisor_r};
        if (trial_s[33]) begin
            step_s = {sr_r[63:0], 1'b0};
        end else begin
            step_s = {trial_s[32:0], sr_r[30:0], 1'b1};
        end
    end

    // Datapath registers: operand latch at start, iteration while running
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_r      <= 6'd0;
            sr_r       <= 65'd0;
            divisor_r  <= 32'd0;
            neg_quot_r <= 1'b0;
            neg_rem_r  <= 1'b0;
        end else begin
            case (state_r)
                DivFree: begin
                    if (start && (divisor != 32'd0)) begin
                        cnt_r      <= 6'd0;
                        sr_r       <= {33'd0, signed_div ? abs32(dividend) : dividend};
                        divisor_r  <= signed_div ? abs32(divisor) : divisor;
                        neg_quot_r <= signed_div & (dividend[31] ^ divisor[31]);
                        neg_rem_r  <= signed_div & dividend[31];
                    end else begin
                        cnt_r      <= cnt_r;
                        sr_r       <= sr_r;
                        divisor_r  <= divisor_r;
                        neg_quot_r <= neg_quot_r;
                        neg_rem_r  <= neg_rem_r;
                    end
                end
                DivByZero: begin
                    sr_r       <= 65'd0;
                    neg_quot_r <= 1'b0;
                    neg_rem_r  <= 1'b0;
                end
                DivOn: begin
                    sr_r  <= step_s;
                    cnt_r <= cnt_r + 6'd1;
                end
                DivEnd: begin
                    sr_r <= sr_r;
                end
                default: begin
                    sr_r <= sr_r;
                end
            endcase
        end
    end

    // Outputs: sign-corrected result presented only in the final state
    always_comb begin
        state = state_r;
        ready = 1'b0;
        quot  = 32'd0;
        rem   = 32'd0;
        case (state_r)
            DivEnd: begin
                ready = 1'b1;
                quot  = neg_quot_r ? neg32(sr_r[31:0])  : sr_r[31:0];
                rem   = neg_rem_r  ? neg32(sr_r[63:32]) : sr_r[63:32];
            end
            default: begin
                ready = 1'b0;
                quot  = 32'd0;
                rem   = 32'd0;
            end
        endcase
    end

endmodule

// File: rtl/ex.sv
// MIPS32 execute stage: combinational logic/shift/arithmetic results with
// same-cycle forwarding, plus the multi-cycle divider writing HI/LO.
module ex
    import ex_pkg::*;
(
    input  logic clk,
    input  logic rst,
    ex_if.slave  bus
);

    logic        is_div_s;
    logic        is_signed_s;
    logic [31:0] logic_res_s;
    logic [31:0] shift_res_s;
    logic [31:0] arith_res_s;
    logic [31:0] alu_res_s;
    div_state_e  div_state_s;
    logic        div_ready_s;
    logic [31:0] div_quot_s;
    logic [31:0] div_rem_s;

    // Divide detection; the divider only acts on this while idle
    always_comb begin
        is_div_s    = (bus.aluop_i == EXE_DIV_OP) || (bus.aluop_i == EXE_DIVU_OP);
        is_signed_s = (bus.aluop_i == EXE_DIV_OP);
    end

    ex_div u_div (
        .clk        (clk),
        .rst        (rst),
        .start      (is_div_s),
        .signed_div (is_signed_s),
        .dividend   (bus.reg1_i),
        .divisor    (bus.reg2_i),
        .state      (div_state_s),
        .ready      (div_ready_s),
        .quot       (div_quot_s),
        .rem        (div_rem_s)
    );

    // Bitwise logic unit
    always_comb begin
        case (bus.aluop_i)
            EXE_OR_OP:  logic_res_s = bus.reg1_i | bus.reg2_i;
            EXE_AND_OP: logic_res_s = bus.reg1_i & bus.reg2_i;
            EXE_XOR_OP: logic_res_s = bus.reg1_i ^ bus.reg2_i;
            EXE_NOR_OP: logic_res_s = ~(bus.reg1_i | bus.reg2_i);
            default:    logic_res_s = 32'd0;
        endcase
    end

    // Shifter: reg2 is shifted by reg1[4:0]
    always_comb begin
        case (bus.aluop_i)
            EXE_SLL_OP: shift_res_s = bus.reg2_i << bus.reg1_i[4:0];
            EXE_SRL_OP: shift_res_s = bus.reg2_i >> bus.reg1_i[4:0];
            EXE_SRA_OP: shift_res_s = $unsigned($signed(bus.reg2_i) >>> bus.reg1_i[4:0]);
            default:    shift_res_s = 32'd0;
        endcase
    end

    // Wrapping add/subtract and set-on-less-than
    always_comb begin
        case (bus.aluop_i)
            EXE_ADDU_OP: arith_res_s = bus.reg1_i + bus.reg2_i;
            EXE_SUBU_OP: arith_res_s = bus.reg1_i - bus.reg2_i;
            EXE_SLT_OP:  arith_res_s = ($signed(bus.reg1_i) < $signed(bus.reg2_i)) ? 32'd1 : 32'd0;
            EXE_SLTU_OP: arith_res_s = (bus.reg1_i < bus.reg2_i) ? 32'd1 : 32'd0;
            default:     arith_res_s = 32'd0;
        endcase
    end

    // Result class select
    always_comb begin
        case (bus.alusel_i)
            EXE_RES_LOGIC: alu_res_s = logic_res_s;
            EXE_RES_SHIFT: alu_res_s = shift_res_s;
            EXE_RES_ARITH: alu_res_s = arith_res_s;
            default:       alu_res_s = 32'd0;
        endcase
    end

    // Stage outputs, all forced to zero while reset is held
    always_comb begin
        if (rst) begin
            bus.wd_o       = 5'd0;
            bus.wreg_o     = 1'b0;
            bus.wdata_o    = 32'd0;
            bus.whilo_o    = 1'b0;
            bus.hi_o       = 32'd0;
            bus.lo_o       = 32'd0;
            bus.stallreq_o = 1'b0;
        end else begin
            bus.wd_o    = bus.wd_i;
            bus.wreg_o  = bus.wreg_i;
            bus.wdata_o = alu_res_s;
            bus.whilo_o = div_ready_s;
            bus.hi_o    = div_rem_s;
            bus.lo_o    = div_quot_s;
            case (div_state_s)
                DivFree:   bus.stallreq_o = is_div_s;
                DivByZero: bus.stallreq_o = 1'b1;
                DivOn:     bus.stallreq_o = 1'b1;
                DivEnd:    bus.stallreq_o = 1'b0;
                default:   bus.stallreq_o = 1'b0;
            endcase
        end
    end

endmodule

// File: doc/ex.md
# ex

Execute stage of the five-stage MIPS32 integer pipeline, fed by the id_ex pipeline register and driving ex_mem. It computes logic, shift and arithmetic results and drives the same-cycle forwarding bus back to `id`: `ex_wreg_i`, `ex_wdata_i` and `ex_wd_i` are connected to this block's `wreg_o`, `wdata_o` and `wd_o`. It also contains an iterative 32-cycle divider for DIV/DIVU. The divider asserts a stall request while busy and writes its result to HI/LO.

## Interface
Parameters: none; widths come from `defines.h` (`RegBus` 32, `RegAddrBus` 5, `AluOpBus` 8, `AluSelBus` 3).

Ports:
- `clk` in 1: pipeline clock; all state on rising edge.
- `rst` in 1: synchronous, active-high (`RstEnable`) reset.
- `aluop_i` in 8: operation code from id_ex.
- `alusel_i` in 3: result class from id_ex.
- `reg1_i` in 32: operand 1 from id_ex.
- `reg2_i` in 32: operand 2 from id_ex.
- `wd_i` in 5: destination register.
- `wreg_i` in 1: register write enable.
- `wd_o` out 5: destination register to ex_mem and the forwarding bus.
- `wreg_o` out 1: register write enable to ex_mem and the forwarding bus.
- `wdata_o` out 32: result to ex_mem and the forwarding bus; combinational in the same cycle.
- `whilo_o` out 1: HI/LO write enable.
- `hi_o` out 32: HI write data (remainder).
- `lo_o` out 32: LO write data (quotient).
- `stallreq_o` out 1: asks pipeline control to hold PC, if_id and id_ex.

## Operation
- **Logic ops** (`EXE_RES_LOGIC`): OR, AND, XOR, NOR of `reg1_i` and `reg2_i`.
- **Shift ops** (`EXE_RES_SHIFT`):
  - Shift amount is `reg1_i[4:0]`; the shifted value is `reg2_i`.
  - SLL and SRL shift in zeros.
  - SRA replicates `reg2_i[31]`.
- **Arithmetic ops** (`EXE_RES_ARITH`):
  - ADDU and SUBU wrap modulo 2^32 and raise no overflow.
  - SLT is a signed compare giving 1 or 0; SLTU is an unsigned compare.
- `EXE_RES_NOP` or an unknown `alusel_i` gives `wdata_o` = 0.
- `wd_o` and `wreg_o` pass through combinationally. DIV/DIVU arrive with `wreg_i` = 0.
- **Divider FSM** states: `DivFree`, `DivByZero`, `DivOn`, `DivEnd`.
  - `DivFree`, with aluop DIV/DIVU and `reg2_i` = 0: go to `DivByZero`.
  - `DivFree`, with aluop DIV/DIVU and `reg2_i` ≠ 0: latch operands, clear `cnt` (6 bits), go to `DivOn`.
  - DIV latches absolute values and records the sign of the quotient and of the remainder. DIVU latches operands unchanged.
  - `DivOn`: one restoring step per cycle on a 65-bit {rem, quot} shift register (trial subtract, set quotient bit). `cnt` increments; after the step at `cnt` = 31, go to `DivEnd`.
  - `DivByZero`: one cycle, result quotient = 0 and remainder = 0, then go to `DivEnd`.
  - `DivEnd`: signed fix-up is applied. Quotient is negated if dividend and divisor signs differ; remainder takes the dividend's sign.
  - `DivEnd`: `lo_o` = quotient, `hi_o` = remainder, `whilo_o` = 1, `stallreq_o` = 0. Next state is `DivFree` unconditionally.
- `stallreq_o` = 1 in `DivFree` when a divide is presented, and in `DivByZero` and `DivOn`. It is 0 otherwise.
- Operands are latched at start; input changes during `DivOn` are ignored.

## Timing
- Non-divide results are combinational with zero latency; `wdata_o` is valid in the same cycle as the inputs.
- Divide with non-zero divisor:
  - Start cycle plus 32 `DivOn` cycles give 33 stall cycles.
  - The result appears in cycle 34 (`DivEnd`) and the pipeline advances at the end of that cycle.
- Divide by zero: 2 stall cycles, result in cycle 3.
- Back-to-back divides: the second divide starts in the cycle after `DivEnd`, from `DivFree`.
- Reset values:
  - FSM = `DivFree`, `cnt` = 0, divider registers = 0.
  - Every output is 0 while `rst` = 1, including the combinational ones.
- Reset mid-division: the divider aborts and the state returns to `DivFree` on that edge. There is no HI/LO write and `stallreq_o` = 0 from that cycle.

## Structure
- `defines.h` gains:
  - aluop codes `EXE_AND_OP`, `EXE_XOR_OP`, `EXE_NOR_OP`, `EXE_SLL_OP`, `EXE_SRL_OP`, `EXE_SRA_OP`, `EXE_ADDU_OP`, `EXE_SUBU_OP`, `EXE_SLT_OP`, `EXE_SLTU_OP`, `EXE_DIV_OP`, `EXE_DIVU_OP`;
  - result classes `EXE_RES_SHIFT` and `EXE_RES_ARITH`;
  - FSM encodings `DivFree`, `DivByZero`, `DivOn`, `DivEnd` (2 bits).
- Sub-module `div`: owns the FSM, counter and shift register. Its interface is start/signed/operands in and ready/result out. `ex` muxes its outputs and derives `stallreq_o`.

## Test plan
- OR with `reg1_i` = 0xFFFF0000, `reg2_i` = 0x00001234 → `wdata_o` = 0xFFFF1234 in the same cycle; `wd_o` and `wreg_o` forwarded.
- SRA with `reg1_i` = 4, `reg2_i` = 0x80000000 → 0xF8000000. SLT(-1, 1) → 1; SLTU(-1, 1) → 0.
- DIV 100/7 → 33 cycles of `stallreq_o`, then `lo_o` = 14, `hi_o` = 2, `whilo_o` pulsed for one cycle.
- DIV -7/2 → `lo_o` = 0xFFFFFFFD, `hi_o` = 0xFFFFFFFF. DIVU 0xFFFFFFFF/16 → `lo_o` = 0x0FFFFFFF, `hi_o` = 0xF.
- DIVU x/0 → 2 stall cycles, then `hi_o` = `lo_o` = 0 with `whilo_o` = 1.
- `rst` asserted at `cnt` = 10 → FSM returns to `DivFree`, `stallreq_o` = 0, no `whilo_o`; a following DIV 9/3 gives `lo_o` = 3, `hi_o` = 0.
